// File: rtl/threshold_bank_if.sv
// threshold_bank_if: user-input write bus of the threshold bank.
// The master drives one operation per cycle with select high; the slave
// answers one cycle later with a single-cycle wr_ack or wr_err pulse.
interface threshold_bank_if #(
  parameter int SEL_W = 2,
  parameter int IN_W  = 3
) ();
  logic             select;
  logic [SEL_W-1:0] selector;
  logic [1:0]       mode;
  logic [IN_W-1:0]  inputVal;
  logic             wr_ack;
  logic             wr_err;

  modport master (
    output select, selector, mode, inputVal,
    input  wr_ack, wr_err
  );

  modport slave (
    input  select, selector, mode, inputVal,
    output wr_ack, wr_err
  );
endinterface

// File: rtl/threshold_bank.sv
// threshold_bank: per-channel threshold registers for the colour-reduction
// path (channel 0 = hue, 1 = saturation, 2 = value by default).
// Write modes: 00 load (operand scaled to the top bits), 01 saturating
// increment, 10 saturating decrement, 11 reserved (rejected).
// Optional feature macro THRESHOLD_SHADOW_EN: when defined, writes land in a
// shadow register and reach the thresholds output only on a commit pulse, so
// a threshold never changes mid-frame. When undefined, writes go straight to
// the active register, commit is ignored and pending stays 0.
module threshold_bank #(
  parameter int              NUM_CH   = 3,
  parameter int              SEL_W    = 2,
  parameter int              IN_W     = 3,
  parameter int              TH_W     = 8,
  parameter logic [TH_W-1:0] RESET_TH = 8'h80
) (
  input  logic                   clk,
  input  logic                   reset,
  threshold_bank_if.slave        bus,
  input  logic                   commit,
  output logic [NUM_CH*TH_W-1:0] thresholds,
  output logic                   pending
);

  // Channel count widened by one bit so out-of-range selectors compare safely.
  localparam logic [SEL_W:0] NUM_CH_L = (SEL_W + 1)'(NUM_CH);

  logic op_valid;
  logic op_reject;
  logic ack_reg;
  logic err_reg;

  assign op_valid  = bus.select && ({1'b0, bus.selector} < NUM_CH_L) && (bus.mode != 2'b11);
  assign op_reject = bus.select && !op_valid;

  assign bus.wr_ack = ack_reg;
  assign bus.wr_err = err_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic            hit;
      logic [TH_W-1:0] cur;
      logic [TH_W:0]   sum;
      logic [TH_W:0]   diff;
      logic [TH_W-1:0] wr_val;

      assign hit  = op_valid && (bus.selector == SEL_W'(gi));
      // One spare bit catches the carry / borrow used for clamping.
      assign sum  = {1'b0, cur} + (TH_W + 1)'(bus.inputVal);
      assign diff = {1'b0, cur} - (TH_W + 1)'(bus.inputVal);

      // New value for this channel according to the requested mode.
      always_comb begin
        wr_val = cur;
        case (bus.mode)
          2'b00:   wr_val = TH_W'(bus.inputVal) << (TH_W - IN_W);
          2'b01:   wr_val = sum[TH_W]  ? {TH_W{1'b1}} : sum[TH_W-1:0];
          2'b10:   wr_val = diff[TH_W] ? {TH_W{1'b0}} : diff[TH_W-1:0];
          default: wr_val = cur;
        endcase
      end

`ifdef THRESHOLD_SHADOW_EN
      logic [TH_W-1:0] shadow_reg;
      logic [TH_W-1:0] active_reg;

      // Arithmetic chains on the shadow copy so back-to-back ops accumulate.
      assign cur = shadow_reg;

      // Writes land in shadow; commit copies the pre-write shadow to active.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          shadow_reg <= RESET_TH;
          active_reg <= RESET_TH;
        end else begin
          if (hit)
            shadow_reg <= wr_val;
          if (commit)
            active_reg <= shadow_reg;
        end
      end
`else
      logic [TH_W-1:0] active_reg;

      assign cur = active_reg;

      // Without shadowing, writes update the visible threshold directly.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset)
          active_reg <= RESET_TH;
        else if (hit)
          active_reg <= wr_val;
      end
`endif

      assign thresholds[gi*TH_W +: TH_W] = active_reg;
    end
  endgenerate

`ifdef THRESHOLD_SHADOW_EN
  logic pending_reg;

  assign pending = pending_reg;

  // Response pulses and pending flag; a write in the commit cycle keeps pending set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ack_reg     <= 1'b0;
      err_reg     <= 1'b0;
      pending_reg <= 1'b0;
    end else begin
      ack_reg <= op_valid;
      err_reg <= op_reject;
      if (op_valid)
        pending_reg <= 1'b1;
      else if (commit)
        pending_reg <= 1'b0;
    end
  end
`else
  logic unused_commit;

  // Commit has no role when writes go straight to the active registers.
  assign unused_commit = commit;
  assign pending       = 1'b0;

  // Response pulses, one cycle after the sampled operation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ack_reg <= 1'b0;
      err_reg <= 1'b0;
    end else begin
      ack_reg <= op_valid;
      err_reg <= op_reject;
    end
  end
`endif

endmodule
